// File: rtl/alu_pkg.sv
// Shared definitions for the ALU requester controller: opcodes, response
// flag bit positions and controller FSM states.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam int FLG_OVF  = 0;
    localparam int FLG_DBZ  = 1;
    localparam int FLG_ZERO = 2;
    localparam int FLG_TMO  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } ctrl_state_t;

    function automatic logic [3:0] pack_flags(input logic tmo, input logic zero,
                                              input logic dbz, input logic ovf);
        logic [3:0] f;
        f           = '0;
        f[FLG_TMO]  = tmo;
        f[FLG_ZERO] = zero;
        f[FLG_DBZ]  = dbz;
        f[FLG_OVF]  = ovf;
        return f;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous show-ahead command FIFO; pointers carry one extra wrap bit so
// full and empty are distinguished by comparing the MSBs.
module alu_cmd_fifo #(
    parameter int W     = 18,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         do_push;
    logic         do_pop;

    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty   = (wptr == rptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rptr <= rptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/alu_req_ctrl.sv
// Requester-side controller for the ALU start/done interface: queues commands,
// issues them one at a time, waits for done or timeout, returns the result.
module alu_req_ctrl
    import alu_pkg::*;
#(
    parameter int N          = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [N-1:0]   cmd_a,
    input  logic [N-1:0]   cmd_b,
    input  logic [1:0]     cmd_op,
    output logic           alu_start,
    output logic [N-1:0]   alu_a,
    output logic [N-1:0]   alu_b,
    output logic [1:0]     alu_opcode,
    input  logic [2*N-1:0] alu_result,
    input  logic           alu_done,
    input  logic           alu_overflow,
    input  logic           alu_div_by_zero,
    input  logic           alu_zero,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [2*N-1:0] rsp_result,
    output logic [3:0]     rsp_flags,
    output logic           busy
);

    localparam int FW = 2*N + 2;
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    ctrl_state_t   state;
    logic [CW-1:0] wait_cnt;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [FW-1:0] fifo_rd;

    assign cmd_ready = !fifo_full;
    assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
    assign busy      = (state != ST_IDLE) || !fifo_empty;

    alu_cmd_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (cmd_valid && cmd_ready),
        .wr_data ({cmd_a, cmd_b, cmd_op}),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // alu_start is registered, so it is set on the ISSUE->WAIT edge; the pulse
    // occupies the first WAIT cycle, where wait_cnt==0 masks any stale done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            alu_start  <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
        end else begin
            alu_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        {alu_a, alu_b, alu_opcode} <= fifo_rd;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    alu_start <= 1'b1;
                    wait_cnt  <= '0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt + CW'(1);
                    if (alu_done && (wait_cnt != '0)) begin
                        rsp_result <= alu_result;
                        rsp_flags  <= pack_flags(1'b0, alu_zero, alu_div_by_zero, alu_overflow);
                        rsp_valid  <= 1'b1;
                        state      <= ST_RESP;
                    end else if (wait_cnt == CNT_LAST) begin
                        rsp_result <= '0;
                        rsp_flags  <= pack_flags(1'b1, 1'b0, 1'b0, 1'b0);
                        rsp_valid  <= 1'b1;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_ctrl.sv
// Directed bench for alu_req_ctrl with a behavioural ALU responder.
module tb_alu_req_ctrl;
    import alu_pkg::*;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic [1:0]  cmd_op;
    logic        alu_start;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [1:0]  alu_opcode;
    logic [15:0] alu_result;
    logic        alu_done;
    logic        alu_overflow;
    logic        alu_div_by_zero;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        busy;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned model_lat = 3;
    logic        model_hang = 1'b0;
    logic        late_done = 1'b0;

    always #5 clk = ~clk;

    alu_req_ctrl #(
        .N          (8),
        .FIFO_DEPTH (4),
        .TIMEOUT    (TMO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_a           (cmd_a),
        .cmd_b           (cmd_b),
        .cmd_op          (cmd_op),
        .alu_start       (alu_start),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_opcode      (alu_opcode),
        .alu_result      (alu_result),
        .alu_done        (alu_done),
        .alu_overflow    (alu_overflow),
        .alu_div_by_zero (alu_div_by_zero),
        .alu_zero        (alu_zero),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_result      (rsp_result),
        .rsp_flags       (rsp_flags),
        .busy            (busy)
    );

    // ALU responder: sees start at a falling edge, raises done model_lat
    // falling edges later for one cycle.
    initial begin
        logic [8:0]  s;
        logic [15:0] r;
        alu_done = 1'b0; alu_result = '0; alu_overflow = 1'b0;
        alu_div_by_zero = 1'b0; alu_zero = 1'b0;
        forever begin
            @(negedge clk);
            alu_done = late_done;
            if (alu_start && !model_hang) begin
                alu_overflow = 1'b0;
                alu_div_by_zero = 1'b0;
                case (alu_opcode)
                    OP_ADD: begin s = {1'b0, alu_a} + {1'b0, alu_b}; r = {8'd0, s[7:0]}; alu_overflow = s[8]; end
                    OP_SUB: begin s = {1'b0, alu_a} - {1'b0, alu_b}; r = {8'd0, s[7:0]}; alu_overflow = s[8]; end
                    OP_MUL: begin r = alu_a * alu_b; alu_overflow = |r[15:8]; end
                    default: begin
                        if (alu_b == 8'd0) begin r = '0; alu_div_by_zero = 1'b1; end
                        else r = {8'd0, alu_a / alu_b};
                    end
                endcase
                alu_result = r;
                alu_zero = (r == 16'd0);
                repeat (model_lat) @(negedge clk);
                alu_done = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        int unsigned w = 0;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        while (!cmd_ready && w < 300) begin
            tick();
            w++;
        end
        check("push_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input logic [15:0] exp_res, input logic [3:0] exp_flg);
        int unsigned w = 0;
        while (!rsp_valid && w < 300) begin
            tick();
            w++;
        end
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_result"}, 32'(rsp_result), 32'(exp_res));
        check({tag, "_flags"}, 32'(rsp_flags), 32'(exp_flg));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned cyc;
        int unsigned n_start;
        int unsigned n_rsp;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b0;
        #22;
        check("rst_start", 32'(alu_start), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_result", 32'(rsp_result), 32'd0);
        check("rst_rsp_flags", 32'(rsp_flags), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // ADD with latency and pulse-width checks; push returns just after edge T
        push(8'd100, 8'd50, OP_ADD);
        check("add_busy", 32'(busy), 32'd1);
        tick();
        check("add_start_t1", 32'(alu_start), 32'd0);
        tick();
        check("add_start_t2", 32'(alu_start), 32'd1);
        check("add_alu_a", 32'(alu_a), 32'd100);
        check("add_alu_b", 32'(alu_b), 32'd50);
        check("add_alu_op", 32'(alu_opcode), 32'd0);
        tick();
        check("add_start_t3", 32'(alu_start), 32'd0);
        check("add_hold_a", 32'(alu_a), 32'd100);
        tick();
        tick();
        check("add_rsp_before_done", 32'(rsp_valid), 32'd0);
        tick();
        check("add_rsp_after_done", 32'(rsp_valid), 32'd1);
        wait_rsp("add", 16'd150, 4'b0000);
        tick();
        check("add_idle_busy", 32'(busy), 32'd0);

        wait_rsp_div: begin
            push(8'd100, 8'd0, OP_DIV);
            wait_rsp("div0", 16'd0, 4'b0110);
        end

        push(8'd255, 8'd1, OP_ADD);
        push(8'd255, 8'd255, OP_MUL);
        wait_rsp("ovf_add", 16'd0, 4'b0101);
        wait_rsp("ovf_mul", 16'd65025, 4'b0001);

        // Earliest honoured done: one cycle after the start pulse
        model_lat = 1;
        push(8'd9, 8'd4, OP_SUB);
        wait_rsp("sub_lat1", 16'd5, 4'b0000);
        model_lat = 3;

        // Backpressure: one response held, four queued, sixth refused
        for (int i = 0; i < 5; i++) push(8'(i + 1), 8'd10, OP_ADD);
        check("bp_full_ready", 32'(cmd_ready), 32'd0);
        repeat (20) tick();
        check("bp_held_valid", 32'(rsp_valid), 32'd1);
        check("bp_held_result", 32'(rsp_result), 32'd11);
        check("bp_still_full", 32'(cmd_ready), 32'd0);
        fork
            push(8'd6, 8'd10, OP_ADD);
            begin
                wait_rsp("bp1", 16'd11, 4'b0000);
                wait_rsp("bp2", 16'd12, 4'b0000);
                wait_rsp("bp3", 16'd13, 4'b0000);
                wait_rsp("bp4", 16'd14, 4'b0000);
                wait_rsp("bp5", 16'd15, 4'b0000);
                wait_rsp("bp6", 16'd16, 4'b0000);
            end
        join
        tick();

        // Timeout: ALU never answers
        model_hang = 1'b1;
        push(8'd7, 8'd7, OP_MUL);
        cyc = 0;
        while (!alu_start && cyc < 50) begin tick(); cyc++; end
        check("tmo_start_seen", 32'(alu_start), 32'd1);
        cyc = 0;
        while (!rsp_valid && cyc < 200) begin tick(); cyc++; end
        check("tmo_latency", cyc, 32'(TMO));
        check("tmo_result", 32'(rsp_result), 32'd0);
        check("tmo_flags", 32'(rsp_flags), 32'b1000);
        late_done = 1'b1;
        tick();
        tick();
        late_done = 1'b0;
        tick();
        check("late_done_valid", 32'(rsp_valid), 32'd1);
        check("late_done_flags", 32'(rsp_flags), 32'b1000);
        check("late_done_result", 32'(rsp_result), 32'd0);
        wait_rsp("tmo", 16'd0, 4'b1000);
        model_hang = 1'b0;

        // Done coinciding with the start pulse is stale and must be masked
        model_lat = 0;
        push(8'd1, 8'd2, OP_ADD);
        wait_rsp("stale_done", 16'd0, 4'b1000);
        model_lat = 3;
        tick();

        // Reset during the first WAIT cycle with two commands queued
        model_hang = 1'b1;
        push(8'd1, 8'd1, OP_ADD);
        push(8'd2, 8'd2, OP_ADD);
        push(8'd3, 8'd3, OP_ADD);
        check("mid_start", 32'(alu_start), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_start", 32'(alu_start), 32'd0);
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(cmd_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        model_hang = 1'b0;
        n_start = 0;
        n_rsp = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (alu_start) n_start++;
            if (rsp_valid) n_rsp++;
        end
        check("post_rst_starts", n_start, 32'd0);
        check("post_rst_rsps", n_rsp, 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_req_ctrl.md
Name: alu_req_ctrl

Overview:
Requester-side controller for the 2-operand ALU's start/done interface.
- Accepts operation commands over a valid/ready port and buffers them in a small FIFO.
- Issues each command to the ALU with a one-cycle start pulse, waits for done (with timeout), and captures result plus flags.
- Returns each result over a valid/ready response port.
- Sits between the host/sequencer logic and the ALU instance.

Parameters:
N, 8, operand width; result width is 2*N.
FIFO_DEPTH, 4, command FIFO entries (power of two, >=2).
TIMEOUT, 64, max cycles to wait for alu_done before aborting (>=4).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
cmd_valid  in  1  command offered.
cmd_ready  out  1  FIFO can accept; equals !fifo_full.
cmd_a  in  N  operand a.
cmd_b  in  N  operand b.
cmd_op  in  2  opcode: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
alu_start  out  1  one-cycle start pulse to ALU.
alu_a  out  N  operand a to ALU.
alu_b  out  N  operand b to ALU.
alu_opcode  out  2  opcode to ALU.
alu_result  in  2*N  ALU result.
alu_done  in  1  ALU done.
alu_overflow  in  1  ALU overflow flag.
alu_div_by_zero  in  1  ALU divide-by-zero flag.
alu_zero  in  1  ALU zero flag.
rsp_valid  out  1  response available.
rsp_ready  in  1  consumer accepts response.
rsp_result  out  2*N  captured result.
rsp_flags  out  4  {timeout, zero, div_by_zero, overflow}.
busy  out  1  FSM not IDLE or FIFO non-empty.

Behaviour:
- Reset (async, rst_n=0): FIFO emptied; FSM to IDLE. All outputs 0, except cmd_ready, which is 1.
- Push: cmd_valid & cmd_ready at a rising edge writes {a,b,op} into the FIFO.
- Pop: a pop in the same cycle does not raise cmd_ready that cycle. cmd_ready is registered from the fill level.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if FIFO non-empty, pop the head, register it onto alu_a/alu_b/alu_opcode, go to ISSUE.
- ISSUE: alu_start=1 for exactly this one cycle. Clear the wait counter. Go to WAIT.
- WAIT: alu_a/alu_b/alu_opcode held stable. The counter increments each cycle.
  - alu_done is honoured only when counter >= 1, which masks a stale done from the previous op.
  - On honoured done: capture alu_result into rsp_result and {0, alu_zero, alu_div_by_zero, alu_overflow} into rsp_flags. Go to RESP.
  - If counter reaches TIMEOUT-1 without done: rsp_result=0, rsp_flags=4'b1000. Go to RESP.
  - Done and timeout in the same cycle: done wins.
- RESP: rsp_valid=1. rsp_result/rsp_flags are stable until rsp_valid & rsp_ready.
  - On handshake: go to IDLE. rsp_valid drops the next cycle.
  - alu_done is ignored here.
  - The FIFO keeps accepting commands while in RESP.
- Latency (idle, empty FIFO):
  - Command accepted at edge T; alu_start high in cycle T+2.
  - alu_done sampled at edge D; rsp_valid high in cycle D+1.
  - Back-to-back ops have 1 idle cycle minimum between RESP handshake and the next alu_start.
- Operand outputs retain their last values in IDLE. ALU inputs are don't-care when start=0.
- Reset mid-operation: immediate abort. No response is produced for in-flight or queued commands. alu_start returns to 0 asynchronously.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH. full/empty are derived from the MSB compare.

Decomposition:
- Shared package alu_pkg:
  - opcode constants OP_ADD/OP_SUB/OP_MUL/OP_DIV.
  - rsp_flags bit indices FLG_OVF=0, FLG_DBZ=1, FLG_ZERO=2, FLG_TMO=3.
  - FSM state encoding.
- Sub-module alu_cmd_fifo: synchronous FIFO of width 2*N+2, with push/pop/full/empty.

Test Plan:
- ADD: cmd a=100,b=50,op=00; ALU model returns 150 after 3 cycles -> rsp_result=150, rsp_flags=0000; alu_start exactly 1 cycle wide.
- DIV by zero: a=100,b=0,op=11; model returns 0, div_by_zero=1, zero=1 -> rsp_result=0, rsp_flags=0110.
- Overflow: a=255,b=1,op=00, then a=255,b=255,op=10 back-to-back -> responses in order: {0, 0101}, then {65025, 0001}.
- Backpressure: rsp_ready=0, push 6 commands -> one held in RESP, FIFO full with 4; cmd_ready low after 5 accepted. Release rsp_ready -> all 5 returned in order; 6th accepted once space frees.
- Timeout: ALU model never asserts done -> rsp_valid exactly TIMEOUT cycles after ISSUE; rsp_result=0, rsp_flags=1000. A late alu_done during RESP is ignored.
- Reset mid-WAIT: rst_n=0 while in WAIT with 2 queued -> alu_start/rsp_valid/busy=0 immediately, cmd_ready=1. After release, no stale response is emitted.
